// File: rtl/core_frame_receiver.sv
// core_frame_receiver: core-side endpoint of the scheduler-to-core task bus.
// Accepts a task header and instruction frames, stores them in a local
// instruction memory, launches the core, and reports ready again when the
// core signals completion.
module core_frame_receiver #(
  parameter int INSTR_SIZE  = 16,
  parameter int BUS_TO_CORE = 16,
  parameter int FRAME_SIZE  = 256,
  parameter int FRAME_NUM   = 64,
  localparam int FRAME_WORDS = FRAME_SIZE / INSTR_SIZE,
  localparam int LOCAL_DEPTH = FRAME_NUM * FRAME_WORDS,
  localparam int AW          = $clog2(LOCAL_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_being_sent,
  input  logic                   core_sel,
  input  logic [BUS_TO_CORE-1:0] bus_data,
  output logic                   core_reading,
  output logic                   core_ready,
  output logic                   exec_start,
  input  logic                   exec_done,
  output logic [5:0]             task_frames,
  output logic                   task_sync,
  output logic [5:0]             frames_rcvd,
  output logic                   hdr_err,
  input  logic [AW-1:0]          instr_addr,
  output logic [INSTR_SIZE-1:0]  instr_data
);

  localparam int OW = $clog2(FRAME_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GAP  = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            task_frames_q, task_frames_d;
  logic                  task_sync_q, task_sync_d;
  logic [5:0]            frames_rcvd_q, frames_rcvd_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic                  exec_start_q, exec_start_d;
  logic                  hdr_err_q, hdr_err_d;
  logic [INSTR_SIZE-1:0] instr_data_q;
  logic                  mem_we;
  logic                  take;
  logic                  frame_end;
  logic [5:0]            frames_next;

  logic [INSTR_SIZE-1:0] mem [LOCAL_DEPTH];

  // Header bits other than the frame count and sync flag carry no meaning here.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus_data[BUS_TO_CORE-1:8], bus_data[6]};

  // Handshake outputs follow directly from the current state.
  always_comb begin
    core_ready   = (state_q == S_IDLE);
    core_reading = (state_q == S_IDLE) || (state_q == S_LOAD);
  end

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d       = state_q;
    task_frames_d = task_frames_q;
    task_sync_d   = task_sync_q;
    frames_rcvd_d = frames_rcvd_q;
    wptr_d        = wptr_q;
    exec_start_d  = 1'b0;
    hdr_err_d     = 1'b0;
    mem_we        = 1'b0;
    take          = frame_being_sent & core_sel & core_reading;
    frame_end     = (wptr_q[OW-1:0] == OW'(FRAME_WORDS - 1));
    frames_next   = frames_rcvd_q + 6'd1;

    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          if (bus_data[5:0] == 6'd0) begin
            hdr_err_d = 1'b1;
          end else begin
            task_frames_d = bus_data[5:0];
            task_sync_d   = bus_data[7];
            frames_rcvd_d = 6'd0;
            wptr_d        = '0;
            state_d       = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (take) begin
          mem_we = ~reset;
          wptr_d = wptr_q + AW'(1);
          if (frame_end) begin
            frames_rcvd_d = frames_next;
            if (frames_next == task_frames_q) begin
              state_d      = S_RUN;
              exec_start_d = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        state_d = S_LOAD;
      end
      S_RUN: begin
        if (exec_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and task registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q       <= S_IDLE;
      task_frames_q <= 6'd0;
      task_sync_q   <= 1'b0;
      frames_rcvd_q <= 6'd0;
      wptr_q        <= '0;
      exec_start_q  <= 1'b0;
      hdr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      task_frames_q <= task_frames_d;
      task_sync_q   <= task_sync_d;
      frames_rcvd_q <= frames_rcvd_d;
      wptr_q        <= wptr_d;
      exec_start_q  <= exec_start_d;
      hdr_err_q     <= hdr_err_d;
    end
  end

  // Instruction memory write port.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset so it maps onto plain RAM.
    if (mem_we) mem[wptr_q] <= bus_data;
  end

  // Registered fetch port; a same-edge write to the address returns old data.
  always_ff @(posedge clk) begin
    if (reset) instr_data_q <= '0;
    else       instr_data_q <= mem[instr_addr];
  end

  assign exec_start  = exec_start_q;
  assign hdr_err     = hdr_err_q;
  assign task_frames = task_frames_q;
  assign task_sync   = task_sync_q;
  assign frames_rcvd = frames_rcvd_q;
  assign instr_data  = instr_data_q;

endmodule

// File: tb/tb_core_frame_receiver.sv
// Self-checking bench for core_frame_receiver: randomized valid/data
// stimulus checked against a frame-level reference model.
module tb_core_frame_receiver;

  logic        clk = 1'b0;
  logic        reset, frame_being_sent, core_sel, exec_done;
  logic [15:0] bus_data;
  logic [9:0]  instr_addr;
  logic        core_reading, core_ready, exec_start, task_sync, hdr_err;
  logic [5:0]  task_frames, frames_rcvd;
  logic [15:0] instr_data;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] exp_mem [1024];
  int          low_cycles [$];

  core_frame_receiver dut (
    .clk              (clk),
    .reset            (reset),
    .frame_being_sent (frame_being_sent),
    .core_sel         (core_sel),
    .bus_data         (bus_data),
    .core_reading     (core_reading),
    .core_ready       (core_ready),
    .exec_start       (exec_start),
    .exec_done        (exec_done),
    .task_frames      (task_frames),
    .task_sync        (task_sync),
    .frames_rcvd      (frames_rcvd),
    .hdr_err          (hdr_err),
    .instr_addr       (instr_addr),
    .instr_data       (instr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send a header plus 16*N words; valid is asserted with probability valid_pct.
  task automatic load_task(input logic [15:0] hdr, input logic [15:0] base,
                           input int valid_pct, input bit check_gaps);
    int  n     = int'(hdr[5:0]);
    int  total = n * 16;
    int  k     = 0;
    int  cyc;
    bit  gap   = 1'b0;
    bit  exp_rd, took;
    low_cycles.delete();
    frame_being_sent = 1'b1; core_sel = 1'b1; bus_data = hdr;
    tick();
    cyc = 1;
    compared++; if (core_ready !== 1'b0) begin mismatched++; $display("FAIL hdr_ready: got %b want 0", core_ready); end
    compared++; if (task_frames !== hdr[5:0]) begin mismatched++; $display("FAIL hdr_frames: got %0d want %0d", task_frames, hdr[5:0]); end
    compared++; if (task_sync !== hdr[7]) begin mismatched++; $display("FAIL hdr_sync: got %b want %b", task_sync, hdr[7]); end
    compared++; if (frames_rcvd !== 6'd0) begin mismatched++; $display("FAIL hdr_rcvd: got %0d want 0", frames_rcvd); end
    while (k < total && cyc < 4000) begin
      exp_rd = !gap;
      compared++; if (core_reading !== exp_rd) begin mismatched++; $display("FAIL reading@%0d: got %b want %b", cyc, core_reading, exp_rd); end
      compared++; if (exec_start !== 1'b0) begin mismatched++; $display("FAIL early_start@%0d: got %b want 0", cyc, exec_start); end
      if (core_reading === 1'b0) low_cycles.push_back(cyc);
      frame_being_sent = ($urandom_range(99) < valid_pct);
      bus_data = frame_being_sent ? base + 16'(k) : 16'($urandom);
      took = frame_being_sent && exp_rd;
      tick();
      cyc++;
      if (took) begin
        exp_mem[k] = base + 16'(k);
        k++;
        gap = (k % 16 == 0) && (k < total);
      end else begin
        gap = 1'b0;
      end
    end
    frame_being_sent = 1'b0;
    compared++; if (k != total) begin mismatched++; $display("FAIL load_timeout: got %0d words want %0d", k, total); end
    compared++; if (exec_start !== 1'b1) begin mismatched++; $display("FAIL exec_start: got %b want 1", exec_start); end
    compared++; if (frames_rcvd !== 6'(n)) begin mismatched++; $display("FAIL frames_rcvd: got %0d want %0d", frames_rcvd, n); end
    compared++; if (core_reading !== 1'b0) begin mismatched++; $display("FAIL run_reading: got %b want 0", core_reading); end
    if (valid_pct >= 100) begin
      compared++; if (cyc != 17 * n) begin mismatched++; $display("FAIL load_time: got %0d want %0d", cyc, 17 * n); end
    end
    if (check_gaps) begin
      compared++;
      if (low_cycles.size() != 2 || low_cycles[0] != 17 || low_cycles[1] != 34) begin
        mismatched++;
        $display("FAIL gap_cycles: got %0d lows (first %0d) want 17,34", low_cycles.size(),
                 low_cycles.size() > 0 ? low_cycles[0] : -1);
      end
    end
    tick();
    compared++; if (exec_start !== 1'b0) begin mismatched++; $display("FAIL start_pulse: got %b want 0", exec_start); end
  endtask

  task automatic fetch_check(input logic [9:0] addr, input logic [15:0] expv);
    instr_addr = addr;
    tick();
    compared++; if (instr_data !== expv) begin mismatched++; $display("FAIL fetch[%0d]: got %h want %h", addr, instr_data, expv); end
  endtask

  task automatic finish_task();
    compared++; if (core_ready !== 1'b0) begin mismatched++; $display("FAIL run_ready: got %b want 0", core_ready); end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    compared++; if (core_ready !== 1'b1) begin mismatched++; $display("FAIL done_ready: got %b want 1", core_ready); end
    compared++; if (core_reading !== 1'b1) begin mismatched++; $display("FAIL done_reading: got %b want 1", core_reading); end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_being_sent = 1'b0; core_sel = 1'b0; exec_done = 1'b0;
    bus_data = '0; instr_addr = '0;
    tick(); tick();
    compared++; if (core_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", core_ready); end
    compared++; if (core_reading !== 1'b1) begin mismatched++; $display("FAIL rst_reading: got %b want 1", core_reading); end
    compared++; if ({exec_start, hdr_err, task_sync} !== 3'b000) begin mismatched++; $display("FAIL rst_pulses: got %b want 000", {exec_start, hdr_err, task_sync}); end
    compared++; if ({task_frames, frames_rcvd} !== 12'd0) begin mismatched++; $display("FAIL rst_counts: got %h want 0", {task_frames, frames_rcvd}); end
    compared++; if (instr_data !== 16'h0000) begin mismatched++; $display("FAIL rst_instr: got %h want 0000", instr_data); end
    reset = 1'b0;
    exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (core_ready !== 1'b1 || exec_start !== 1'b0) begin mismatched++; $display("FAIL idle_done: got ready=%b start=%b want 1,0", core_ready, exec_start); end
    end
    exec_done = 1'b0;
  endtask

  task automatic test_basic();
    load_task(16'h0003, 16'h1000, 100, 1'b1);
    compared++; if (task_frames !== 6'd3) begin mismatched++; $display("FAIL basic_frames: got %0d want 3", task_frames); end
    fetch_check(10'd0,  16'h1000);
    fetch_check(10'd16, 16'h1010);
    fetch_check(10'd47, 16'h102F);
    finish_task();
  endtask

  task automatic test_no_sel();
    core_sel = 1'b0; frame_being_sent = 1'b1; bus_data = 16'h0043;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++; if (core_ready !== 1'b1 || task_frames !== 6'd3) begin mismatched++; $display("FAIL no_sel: got ready=%b frames=%0d want 1,3", core_ready, task_frames); end
    end
    frame_being_sent = 1'b0;
  endtask

  task automatic test_hdr_err();
    int pulses = 0;
    core_sel = 1'b1; frame_being_sent = 1'b1; bus_data = 16'h0080;
    tick();
    frame_being_sent = 1'b0;
    pulses += int'(hdr_err);
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(hdr_err);
    end
    compared++; if (pulses != 1) begin mismatched++; $display("FAIL hdr_err_pulses: got %0d want 1", pulses); end
    compared++; if (core_ready !== 1'b1) begin mismatched++; $display("FAIL hdr_err_idle: got %b want 1", core_ready); end
    compared++; if (task_frames !== 6'd3 || task_sync !== 1'b0) begin mismatched++; $display("FAIL hdr_err_keep: got %0d/%b want 3/0", task_frames, task_sync); end
    load_task(16'h0081, 16'($urandom), 100, 1'b0);
    compared++; if (task_sync !== 1'b1) begin mismatched++; $display("FAIL sync_flag: got %b want 1", task_sync); end
    fetch_check(10'd0, exp_mem[0]);
    fetch_check(10'd15, exp_mem[15]);
    finish_task();
  endtask

  task automatic test_stall();
    load_task(16'h0002, 16'($urandom), 50, 1'b0);
    for (int a = 0; a < 32; a++) fetch_check(10'(a), exp_mem[a]);
    finish_task();
  endtask

  task automatic test_reset_mid();
    int k = 0;
    core_sel = 1'b1; frame_being_sent = 1'b1; bus_data = 16'h0002;
    tick();
    for (int c = 0; c < 40 && k < 20; c++) begin
      if (core_reading === 1'b1) k++;
      bus_data = 16'hBEEF;
      tick();
    end
    frame_being_sent = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++; if (core_ready !== 1'b1 || core_reading !== 1'b1) begin mismatched++; $display("FAIL mid_rst_state: got %b%b want 11", core_ready, core_reading); end
    compared++; if (frames_rcvd !== 6'd0 || task_frames !== 6'd0) begin mismatched++; $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", frames_rcvd, task_frames); end
    load_task(16'h0001, 16'($urandom), 100, 1'b0);
    fetch_check(10'd0, exp_mem[0]);
    fetch_check(10'd9, exp_mem[9]);
    fetch_check(10'd15, exp_mem[15]);
    finish_task();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_sel();
    test_hdr_err();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
